if_fetch_unit: RTL and testbench

//  IF-stage fetch sequencer. It executes the stall/flush/next-PC commands issued by the hazard detection unit.
//  It holds the fetch PC and runs a valid/ready request handshake to instruction memory, with one request outstanding.
//  A one-entry skid buffer absorbs responses that arrive during a stall.
//  It drives the IF/ID pipeline register (PC_ID, instr_ID, valid_ID).

---
 rtl/if_fetch_unit_if.sv | 19 +
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the IF fetch sequencer and imem.
// One request may be outstanding; responses carry no tag.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch sequencer: fetch PC, single-outstanding imem handshake,
// one-entry skid buffer and the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_IF,
  input  logic                   flush_ID,
  input  logic [2:0]             NPCOp_in,
  input  logic [31:0]            NPCImm_in,
  input  logic [31:0]            base_PC_in,
  input  logic [31:0]            jalr_target_in,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            PC_ID,
  output logic [31:0]            instr_ID,
  output logic                   valid_ID,
  output logic                   fetch_busy
);

  typedef enum logic {S_REQ, S_WAIT} state_e;
  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JALR   = 3'b100
  } npc_op_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        skid_full_q, skid_full_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;

  logic        redir, req_valid, accept, live, upd, have_instr;
  logic [31:0] target, src_instr, src_pc;

  assign redir      = (NPCOp_in == NPC_BRANCH) || (NPCOp_in == NPC_JUMP) || (NPCOp_in == NPC_JALR);
  assign target     = ((NPCOp_in == NPC_JALR) ? jalr_target_in : (base_PC_in + NPCImm_in)) & 32'hFFFF_FFFC;
  assign req_valid  = (state_q == S_REQ) && !skid_full_q && !rst;
  assign accept     = req_valid && imem.imem_req_ready;
  assign live       = (state_q == S_WAIT) && imem.imem_rsp_valid && !drop_q;
  assign upd        = !stall_IF || flush_ID || redir;
  assign have_instr = skid_full_q || live;
  assign src_instr  = skid_full_q ? skid_instr_q : imem.imem_rsp_data;
  assign src_pc     = skid_full_q ? skid_pc_q : req_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    skid_full_d  = skid_full_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    pc_id_d      = pc_id_q;
    instr_id_d   = instr_id_q;
    valid_id_d   = valid_id_q;

    unique case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d  = S_WAIT;
          req_pc_d = pc_f_q;
          pc_f_d   = pend_q ? pend_pc_q : pc_f_q + 32'd4;
          pend_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect during a stalled handshake keeps imem_addr stable: the target
    // is parked in pend_pc until acceptance and the held request's response is dropped.
    if (redir) begin
      skid_full_d = 1'b0;
      if (accept) begin
        pc_f_d = target;
        drop_d = 1'b1;
      end else if (req_valid) begin
        pend_d    = 1'b1;
        pend_pc_d = target;
        drop_d    = 1'b1;
      end else begin
        pc_f_d = target;
        pend_d = 1'b0;
        if ((state_q == S_WAIT) && !imem.imem_rsp_valid) drop_d = 1'b1;
      end
    end

    if (upd) begin
      valid_id_d  = have_instr && !flush_ID && !redir;
      skid_full_d = 1'b0;
      if (valid_id_d) begin
        pc_id_d    = src_pc;
        instr_id_d = src_instr;
      end else begin
        instr_id_d = NOP_INSTR;
      end
    end else if (live) begin
      skid_full_d  = 1'b1;
      skid_instr_d = imem.imem_rsp_data;
      skid_pc_d    = req_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_f_q       <= RESET_PC;
      req_pc_q     <= RESET_PC;
      drop_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      skid_full_q  <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      pc_id_q      <= '0;
      instr_id_q   <= NOP_INSTR;
      valid_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      skid_full_q  <= skid_full_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      pc_id_q      <= pc_id_d;
      instr_id_q   <= instr_id_d;
      valid_id_q   <= valid_id_d;
    end
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc_f_q;
  assign PC_ID               = pc_id_q;
  assign instr_ID            = instr_id_q;
  assign valid_ID            = valid_id_q;
  assign fetch_busy          = rst || !have_instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a vector table for sequential fetch, stall/skid
// and redirects, plus hand-written sequences for a held handshake and mid-transaction reset.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall_IF, flush_ID;
  logic [2:0]  NPCOp_in;
  logic [31:0] NPCImm_in, base_PC_in, jalr_target_in;
  logic [31:0] PC_ID, instr_ID;
  logic        valid_ID, fetch_busy;
  int unsigned checks = 0;
  int unsigned failures = 0;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .flush_ID(flush_ID),
    .NPCOp_in(NPCOp_in), .NPCImm_in(NPCImm_in), .base_PC_in(base_PC_in),
    .jalr_target_in(jalr_target_in), .imem(imem_bus.master),
    .PC_ID(PC_ID), .instr_ID(instr_ID), .valid_ID(valid_ID), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush;
    logic [2:0]  op;
    logic [31:0] imm, base, jalr;
    logic        ready, rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc, e_instr;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic f, logic [2:0] op, logic [31:0] imm,
                              logic [31:0] base, logic [31:0] jalr, logic rdy, logic rv,
                              logic [31:0] rd, logic e_req, logic [31:0] e_addr, logic e_v,
                              logic [31:0] e_pc, logic [31:0] e_instr, logic e_busy);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.op = op; v.imm = imm; v.base = base;
    v.jalr = jalr; v.ready = rdy; v.rv = rv; v.rd = rd; v.e_req = e_req;
    v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_instr = e_instr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge and settle before sampling.
  task automatic cyc(input logic r, input logic s, input logic f, input logic [2:0] op,
                     input logic [31:0] imm, input logic [31:0] base, input logic [31:0] jalr,
                     input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    rst = r; stall_IF = s; flush_ID = f; NPCOp_in = op; NPCImm_in = imm;
    base_PC_in = base; jalr_target_in = jalr;
    imem_bus.imem_req_ready = rdy; imem_bus.imem_rsp_valid = rv; imem_bus.imem_rsp_data = rd;
    #1;
  endtask

  task automatic idle(input logic rdy, input logic rv, input logic [31:0] rd);
    cyc(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, '0, rdy, rv, rd);
  endtask

  vec_t tbl [24];

  initial begin
    rst = 1'b1; stall_IF = 1'b0; flush_ID = 1'b0; NPCOp_in = '0; NPCImm_in = '0;
    base_PC_in = '0; jalr_target_in = '0;
    imem_bus.imem_req_ready = 1'b0; imem_bus.imem_rsp_valid = 1'b0; imem_bus.imem_rsp_data = '0;
    repeat (2) @(posedge clk);

    //              rst s f op   imm    base         jalr   rdy rv rd             req addr v  PC_ID  instr          busy
    tbl[0]  = mk(1, 0,0,3'd0, 0,     0,           0,     0, 0, 0,            0, 32'h0,   0, 32'h0,  NOP,          1);
    tbl[1]  = mk(0, 0,0,3'd0, 0,     0,           0,     1, 0, 0,            1, 32'h0,   0, 32'h0,  NOP,          1);
    tbl[2]  = mk(0, 0,0,3'd0, 0,     0,           0,     1, 1, 32'hC000_0000,0, 32'h4,   0, 32'h0,  NOP,          0);
    tbl[3]  = mk(0, 0,0,3'd0, 0,     0,           0,     1, 0, 0,            1, 32'h4,   1, 32'h0,  32'hC000_0000,1);
    tbl[4]  = mk(0, 0,0,3'd0, 0,     0,           0,     1, 1, 32'hC000_0004,0, 32'h8,   0, 32'h0,  NOP,          0);
    tbl[5]  = mk(0, 0,0,3'd0, 0,     0,           0,     1, 0, 0,            1, 32'h8,   1, 32'h4,  32'hC000_0004,1);
    tbl[6]  = mk(0, 0,0,3'd0, 0,     0,           0,     1, 1, 32'hC000_0008,0, 32'hC,   0, 32'h4,  NOP,          0);
    tbl[7]  = mk(0, 1,0,3'd0, 0,     0,           0,     1, 0, 0,            1, 32'hC,   1, 32'h8,  32'hC000_0008,1);
    tbl[8]  = mk(0, 1,0,3'd0, 0,     0,           0,     1, 1, 32'hC000_000C,0, 32'h10,  1, 32'h8,  32'hC000_0008,0);
    tbl[9]  = mk(0, 1,0,3'd0, 0,     0,           0,     1, 0, 0,            0, 32'h10,  1, 32'h8,  32'hC000_0008,0);
    tbl[10] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 0, 0,            0, 32'h10,  1, 32'h8,  32'hC000_0008,0);
    tbl[11] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 0, 0,            1, 32'h10,  1, 32'hC,  32'hC000_000C,1);
    tbl[12] = mk(0, 0,0,3'd1, 32'h20,32'h10,      0,     1, 0, 0,            0, 32'h14,  0, 32'hC,  NOP,          1);
    tbl[13] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 1, 32'hDEAD_BEEF,0, 32'h30,  0, 32'hC,  NOP,          1);
    tbl[14] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 0, 0,            1, 32'h30,  0, 32'hC,  NOP,          1);
    tbl[15] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 1, 32'hC000_0030,0, 32'h34,  0, 32'hC,  NOP,          0);
    tbl[16] = mk(0, 0,0,3'd4, 0,     0,           32'h107,1,0, 0,            1, 32'h34,  1, 32'h30, 32'hC000_0030,1);
    tbl[17] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 1, 32'hBAD0_BAD0,0, 32'h104, 0, 32'h30, NOP,          1);
    tbl[18] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 0, 0,            1, 32'h104, 0, 32'h30, NOP,          1);
    tbl[19] = mk(0, 0,0,3'd2, 32'h8, 32'hFFFF_FFFC,0,    1, 1, 32'hC000_0104,0, 32'h108, 0, 32'h30, NOP,          0);
    tbl[20] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 0, 0,            1, 32'h4,   0, 32'h30, NOP,          1);
    tbl[21] = mk(0, 0,0,3'd0, 0,     0,           0,     1, 1, 32'hC000_0004,0, 32'h8,   0, 32'h30, NOP,          0);
    tbl[22] = mk(0, 0,1,3'd0, 0,     0,           0,     0, 0, 0,            1, 32'h8,   1, 32'h4,  32'hC000_0004,1);
    tbl[23] = mk(0, 0,0,3'd0, 0,     0,           0,     0, 0, 0,            1, 32'h8,   0, 32'h4,  NOP,          1);

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].op, tbl[i].imm, tbl[i].base,
          tbl[i].jalr, tbl[i].ready, tbl[i].rv, tbl[i].rd);
      chk($sformatf("v%0d.req_valid", i), 32'(imem_bus.imem_req_valid), 32'(tbl[i].e_req));
      chk($sformatf("v%0d.imem_addr", i), imem_bus.imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d.valid_ID", i),  32'(valid_ID), 32'(tbl[i].e_v));
      chk($sformatf("v%0d.PC_ID", i),     PC_ID, tbl[i].e_pc);
      chk($sformatf("v%0d.instr_ID", i),  instr_ID, tbl[i].e_instr);
      chk($sformatf("v%0d.fetch_busy", i),32'(fetch_busy), 32'(tbl[i].e_busy));
    end

    // Held handshake: ready low for 3 cycles, branch to 0x100 in the 2nd.
    idle(1'b0, 1'b0, '0);
    chk("hold.addr0", imem_bus.imem_addr, 32'h8);
    cyc(1'b0, 1'b0, 1'b0, 3'd1, 32'h0, 32'h100, '0, 1'b0, 1'b0, '0);
    chk("hold.addr1", imem_bus.imem_addr, 32'h8);
    chk("hold.valid1", 32'(imem_bus.imem_req_valid), 32'd1);
    idle(1'b0, 1'b0, '0);
    chk("hold.addr2", imem_bus.imem_addr, 32'h8);
    idle(1'b1, 1'b0, '0);
    chk("hold.addr_acc", imem_bus.imem_addr, 32'h8);
    idle(1'b0, 1'b1, 32'hBADB_AD00);
    chk("hold.drop_busy", 32'(fetch_busy), 32'd1);
    chk("hold.wait_addr", imem_bus.imem_addr, 32'h100);
    idle(1'b1, 1'b0, '0);
    chk("hold.drop_valid", 32'(valid_ID), 32'd0);
    chk("hold.tgt_req", 32'(imem_bus.imem_req_valid), 32'd1);
    chk("hold.tgt_addr", imem_bus.imem_addr, 32'h100);
    idle(1'b0, 1'b1, 32'hC000_0100);
    chk("hold.tgt_busy", 32'(fetch_busy), 32'd0);
    idle(1'b0, 1'b0, '0);
    chk("hold.tgt_v", 32'(valid_ID), 32'd1);
    chk("hold.tgt_pc", PC_ID, 32'h100);
    chk("hold.tgt_instr", instr_ID, 32'hC000_0100);

    // Reset while a request is outstanding; the late response must be ignored.
    idle(1'b1, 1'b0, '0);
    chk("rst.pre_addr", imem_bus.imem_addr, 32'h104);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("rst.req0", 32'(imem_bus.imem_req_valid), 32'd0);
    chk("rst.busy0", 32'(fetch_busy), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 32'hBAD0_0001);
    chk("rst.req1", 32'(imem_bus.imem_req_valid), 32'd0);
    chk("rst.valid1", 32'(valid_ID), 32'd0);
    chk("rst.pc1", PC_ID, 32'h0);
    chk("rst.instr1", instr_ID, NOP);
    chk("rst.addr1", imem_bus.imem_addr, 32'h0);
    idle(1'b0, 1'b1, 32'hBAD0_0002);
    chk("late.req", 32'(imem_bus.imem_req_valid), 32'd1);
    chk("late.busy", 32'(fetch_busy), 32'd1);
    idle(1'b1, 1'b0, '0);
    chk("late.valid", 32'(valid_ID), 32'd0);
    chk("late.addr", imem_bus.imem_addr, 32'h0);
    idle(1'b0, 1'b1, 32'hC000_0000);
    chk("late.next_addr", imem_bus.imem_addr, 32'h4);
    idle(1'b0, 1'b0, '0);
    chk("late.v", 32'(valid_ID), 32'd1);
    chk("late.pc", PC_ID, 32'h0);
    chk("late.instr", instr_ID, 32'hC000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
